// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and state encoding for the serial bus arbiter
package bus_pkg;

  localparam int SLAVE_ADDR_WIDTH = 4;
  localparam int NUM_MASTERS      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SID     = 2'd1,
    WAIT    = 2'd2,
    CONNECT = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-request round-robin arbiter with registered last grant
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // index of the master granted most recently; 1 so master 0 wins the first tie
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && (|req)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - arbitrates two serial masters, receives the slave ID and
// routes the granted master to the selected slave until release
module bus_arbiter #(
  parameter int NUM_SLAVES       = 3,
  parameter int SLAVE_ADDR_WIDTH = bus_pkg::SLAVE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            breq,
  output logic [1:0]            bgrant,
  output logic                  ack,
  output logic                  nack,
  input  logic [1:0]            mwdata,
  input  logic [1:0]            mmode,
  input  logic [1:0]            mvalid,
  output logic                  bwdata,
  output logic                  bmode,
  output logic                  bvalid,
  output logic [NUM_SLAVES-1:0] ssel,
  input  logic [NUM_SLAVES-1:0] sready,
  input  logic [NUM_SLAVES-1:0] srdata,
  input  logic [NUM_SLAVES-1:0] ssvalid,
  output logic                  brdata,
  output logic                  bsvalid
);

  import bus_pkg::*;

  localparam int CW = $clog2(SLAVE_ADDR_WIDTH + 1);
  localparam int XW = 2 ** SLAVE_ADDR_WIDTH;

  state_t                      state;
  logic [SLAVE_ADDR_WIDTH-1:0] id;
  logic [CW-1:0]               cnt;
  logic [1:0]                  arb_grant;
  logic                        gidx;
  logic                        id_ok;
  logic                        id_rdy;
  logic                        connected;
  logic [XW-1:0]               sready_x;

  rr_arbiter_2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (state == IDLE),
    .req   (breq),
    .grant (arb_grant)
  );

  // sready widened to the full ID space so any received ID indexes safely
  assign sready_x = XW'(sready);
  assign gidx     = bgrant[1];
  assign id_ok    = int'(id) < NUM_SLAVES;
  assign id_rdy   = id_ok && sready_x[id];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bgrant <= '0;
      ssel   <= '0;
      ack    <= 1'b0;
      nack   <= 1'b0;
      id     <= '0;
      cnt    <= '0;
    end else begin
      ack  <= 1'b0;
      nack <= 1'b0;
      if (state != IDLE && !breq[gidx]) begin
        state  <= IDLE;
        bgrant <= '0;
        ssel   <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (|breq) begin
              bgrant <= arb_grant;
              state  <= SID;
            end
          end
          SID: begin
            if (cnt == CW'(SLAVE_ADDR_WIDTH)) begin
              cnt <= '0;
              if (!id_ok) begin
                nack   <= 1'b1;
                bgrant <= '0;
                state  <= IDLE;
              end else if (id_rdy) begin
                ssel  <= NUM_SLAVES'(1) << id;
                ack   <= 1'b1;
                state <= CONNECT;
              end else begin
                state <= WAIT;
              end
            end else if (mvalid[gidx]) begin
              // LSB first: each new bit enters at the top and shifts down
              id  <= (id >> 1) | (SLAVE_ADDR_WIDTH'(mwdata[gidx]) << (SLAVE_ADDR_WIDTH - 1));
              cnt <= cnt + CW'(1);
            end
          end
          WAIT: begin
            if (id_rdy) begin
              ssel  <= NUM_SLAVES'(1) << id;
              ack   <= 1'b1;
              state <= CONNECT;
            end
          end
          CONNECT: begin
            state <= CONNECT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    connected = (state == CONNECT);
    bwdata    = connected & mwdata[gidx];
    bmode     = connected & mmode[gidx];
    bvalid    = connected & mvalid[gidx];
    brdata    = connected & (|(srdata & ssel));
    bsvalid   = connected & (|(ssvalid & ssel));
  end

endmodule
